seg7_pattern_decoder: RTL and testbench



---
 rtl/seg7_pattern_decoder.sv | 104 ++++++++++
 tb/tb_seg7_pattern_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: synchronises, debounces and decodes a seven-segment bus, flagging illegal patterns and sequence breaks
module seg7_pattern_decoder #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SEQ_MOD       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       pattern_err,
    output logic       seq_err,
    output logic [7:0] err_count
);
    typedef enum logic {SETTLE, LOCKED} state_t;
    state_t     state;
    logic [6:0] sync1, sync2, acc_pat, pat;
    logic [3:0] stab_cnt, last, value;
    logic [4:0] expect_val;
    logic       first_flag, changed, accept, take, legal, is_blank, seq_bad, err_inc;
    // sync1 != sync2 means sync2 is taking a new value on this edge, so the
    // restart lands on that same edge and the accept meets its latency target
    assign pat        = ACTIVE_LOW ? ~sync2 : sync2;
    assign changed    = sync1 != sync2;
    assign accept     = ena && !changed && state == SETTLE && stab_cnt == 4'(STABLE_CYCLES - 1);
    assign take       = accept && pat != acc_pat;
    assign is_blank   = pat == 7'h00;
    assign expect_val = (5'(last) + 5'd1) % 5'(SEQ_MOD);
    assign seq_bad    = !first_flag && 5'(value) != expect_val;
    assign err_inc    = take && !is_blank && (!legal || seq_bad);
    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (pat)
            7'h3F: value = 4'h0;
            7'h06: value = 4'h1;
            7'h5B: value = 4'h2;
            7'h4F: value = 4'h3;
            7'h66: value = 4'h4;
            7'h6D: value = 4'h5;
            7'h7D: value = 4'h6;
            7'h07, 7'h27: value = 4'h7;
            7'h7F: value = 4'h8;
            7'h6F, 7'h67: value = 4'h9;
            7'h77: value = 4'hA;
            7'h7C: value = 4'hB;
            7'h39: value = 4'hC;
            7'h5E: value = 4'hD;
            7'h79: value = 4'hE;
            7'h71: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= SETTLE;
            stab_cnt    <= '0;
            acc_pat     <= '0;
            first_flag  <= 1'b1;
            last        <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            sync1       <= seg_in;
            sync2       <= sync1;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            if (ena) begin
                if (changed) begin
                    state    <= SETTLE;
                    stab_cnt <= '0;
                end else if (accept) begin
                    state <= LOCKED;
                end else if (state == SETTLE) begin
                    stab_cnt <= stab_cnt + 4'd1;
                end
                if (take) begin
                    acc_pat <= pat;
                    blank   <= is_blank;
                    if (!is_blank && !legal) begin
                        pattern_err <= 1'b1;
                    end else if (!is_blank) begin
                        digit       <= value;
                        digit_valid <= 1'b1;
                        seq_err     <= seq_bad;
                        first_flag  <= 1'b0;
                        last        <= value;
                    end
                end
                if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// tb_seg7_pattern_decoder: directed stimulus checked every cycle against a sample-history model plus literal expectations
module tb_seg7_pattern_decoder;
    localparam int S   = 4;
    localparam int MOD = 8;
    localparam logic [6:0] DIG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, hold = 1'b0, st;
    logic [6:0] seg_in = 7'h7F;
    logic [3:0] digit;
    logic       digit_valid, blank, pattern_err, seq_err;
    logic [7:0] err_count;
    int checks = 0, errors = 0, n_dv = 0, n_pe = 0, n_se = 0, d0, s0, p0;
    logic [6:0] hist [S+2];
    logic [6:0] m_acc;
    logic       m_first;
    logic [3:0] m_last, e_digit;
    logic       e_dv, e_blank, e_pe, e_se;
    logic [7:0] e_err;

    seg7_pattern_decoder #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(S), .SEQ_MOD(MOD)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in), .digit(digit),
        .digit_valid(digit_valid), .blank(blank), .pattern_err(pattern_err),
        .seq_err(seq_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        seg_in = 7'h7F;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [6:0] al(input logic [6:0] p);
        return ~p;
    endfunction

    // {legal, value} for a lit-segment pattern
    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'h3F: return 5'h10;  7'h06: return 5'h11;  7'h5B: return 5'h12;
            7'h4F: return 5'h13;  7'h66: return 5'h14;  7'h6D: return 5'h15;
            7'h7D: return 5'h16;  7'h07: return 5'h17;  7'h27: return 5'h17;
            7'h7F: return 5'h18;  7'h6F: return 5'h19;  7'h67: return 5'h19;
            7'h77: return 5'h1A;  7'h7C: return 5'h1B;  7'h39: return 5'h1C;
            7'h5E: return 5'h1D;  7'h79: return 5'h1E;  7'h71: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    task automatic bump();
        if (e_err != 8'hFF) e_err = e_err + 8'd1;
    endtask

    task automatic m_accept(input logic [6:0] raw);
        logic [6:0] p;
        logic [4:0] d;
        p = ~raw;
        if (p == m_acc) return;
        m_acc = p;
        d = dec(p);
        if (p == 7'h00) begin
            e_blank = 1'b1;
        end else if (!d[4]) begin
            e_blank = 1'b0;
            e_pe = 1'b1;
            bump();
        end else begin
            e_digit = d[3:0];
            e_dv = 1'b1;
            e_blank = 1'b0;
            if (!m_first && int'(d[3:0]) != (int'(m_last) + 1) % MOD) begin
                e_se = 1'b1;
                bump();
            end
            m_first = 1'b0;
            m_last = d[3:0];
        end
    endtask

    // accept at an edge when the previous S+1 bus samples agree and the one before differs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (hist[i]) hist[i] = '0;
            m_acc = '0; m_first = 1'b1; m_last = '0;
            e_digit = '0; e_dv = 1'b0; e_blank = 1'b0; e_pe = 1'b0; e_se = 1'b0; e_err = '0;
        end else begin
            e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0;
            st = hist[S+1] != hist[0];
            for (int i = 1; i <= S; i++) if (hist[i] != hist[0]) st = 1'b0;
            if (st && ena && !hold) m_accept(hist[0]);
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = seg_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n && !hold) begin
            check("digit", digit, e_digit);
            check("digit_valid", digit_valid, e_dv);
            check("blank", blank, e_blank);
            check("pattern_err", pattern_err, e_pe);
            check("seq_err", seq_err, e_se);
            check("err_count", err_count, e_err);
        end
        if (rst_n) begin
            n_dv += digit_valid;
            n_pe += pattern_err;
            n_se += seq_err;
        end
    end

    initial begin
        tick(2);
        check("rst digit", digit, 0);
        check("rst digit_valid", digit_valid, 0);
        check("rst blank", blank, 0);
        check("rst pattern_err", pattern_err, 0);
        check("rst seq_err", seq_err, 0);
        check("rst err_count", err_count, 0);
        rst_n = 1'b1;
        tick(9);
        seg_in = 7'h79;
        tick(5);
        check("lat dv edge14", digit_valid, 0);
        tick(1);
        check("lat dv edge15", digit_valid, 1);
        check("lat digit", digit, 1);
        check("lat seq_err", seq_err, 0);

        do_reset();
        d0 = n_dv;
        for (int v = 0; v < 9; v++) begin
            seg_in = al(DIG[v % 8]);
            tick(8);
        end
        check("step pulses", n_dv - d0, 9);
        check("step err_count", err_count, 0);
        check("step digit", digit, 0);

        do_reset();
        s0 = n_se;
        seg_in = al(7'h5B); tick(8);
        seg_in = al(7'h6D); tick(8);
        check("seq5 digit", digit, 5);
        check("seq5 seq_err count", n_se - s0, 1);
        check("seq5 err_count", err_count, 1);
        seg_in = al(7'h7D); tick(8);
        check("seq6 digit", digit, 6);
        check("seq6 seq_err count", n_se - s0, 1);
        seg_in = 7'h7F; tick(8);
        check("blank level", blank, 1);
        check("blank digit", digit, 6);
        seg_in = al(7'h77); tick(8);
        check("letter digit", digit, 10);
        check("letter blank", blank, 0);
        check("letter err_count", err_count, 2);
        p0 = n_pe;
        seg_in = al(7'h41); tick(8);
        check("illegal pulses", n_pe - p0, 1);
        check("illegal digit", digit, 10);
        check("illegal err_count", err_count, 3);
        tick(30);
        check("illegal held pulses", n_pe - p0, 1);
        check("illegal held err_count", err_count, 3);

        d0 = n_dv;
        for (int i = 0; i < 20; i++) begin
            seg_in = (i % 2 == 0) ? al(7'h06) : al(7'h3F);
            tick(2);
        end
        check("toggle pulses", n_dv - d0, 0);
        seg_in = al(7'h06);
        tick(5);
        check("settle dv early", digit_valid, 0);
        tick(1);
        check("settle dv", digit_valid, 1);
        check("settle digit", digit, 1);

        seg_in = al(7'h5B);
        hold = 1'b1;
        tick(2);
        ena = 1'b0;
        d0 = n_dv;
        tick(5);
        ena = 1'b1;
        tick(3);
        check("ena frozen pulses", n_dv - d0, 0);
        tick(1);
        check("ena resumed dv", digit_valid, 1);
        check("ena resumed digit", digit, 2);
        check("ena resumed seq_err", seq_err, 0);
        m_accept(al(7'h5B));
        hold = 1'b0;

        seg_in = al(7'h3F);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("async rst digit", digit, 0);
        check("async rst err_count", err_count, 0);
        check("async rst blank", blank, 0);
        check("async rst dv", digit_valid, 0);
        tick(2);
        rst_n = 1'b1;
        d0 = n_dv;
        s0 = n_se;
        tick(6);
        check("post rst pulses", n_dv - d0, 1);
        check("post rst digit", digit, 0);
        check("post rst seq_err", n_se - s0, 0);

        p0 = n_pe;
        for (int i = 0; i < 300; i++) begin
            seg_in = (i % 2 == 1) ? al(7'h41) : al(7'h42);
            tick(6);
        end
        check("sat pulses", n_pe - p0, 300);
        check("sat err_count", err_count, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
